// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package loader_pkg;

    localparam int MEM_WORDS_DEF = 32;
    localparam int LANE_W        = 2;
    localparam int WORD_BYTES    = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE,
        ERR
    } ld_state_t;

endpackage

// File: rtl/word_packer.sv
// Packs little-endian stream bytes into a 32-bit instruction word.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);

    logic [LANE_W-1:0] lane;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane <= '0;
            word <= '0;
        end else if (byte_en) begin
            word[{lane, 3'b000} +: 8] <= byte_data;
            lane <= lane + 1'b1;
        end
    end

    assign word_full = byte_en &&
        (lane == LANE_W'(WORD_BYTES - 1));

endmodule

// File: rtl/inst_loader.sv
// Byte-stream program loader: length byte, then packed word writes.
module inst_loader
    import loader_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int ADDR_W    = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           byte_valid,
    input  logic [7:0]                     byte_data,
    output logic                           byte_ready,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic                           cpu_hold,
    output logic                           done,
    output logic                           err,
    output logic [$clog2(MEM_WORDS+1)-1:0] words_loaded
);

    localparam int CNT_W = $clog2(MEM_WORDS + 1);

    ld_state_t         state, nxt;
    logic [CNT_W-1:0]  cnt, n_len, cnt_inc;
    logic [31:0]       word;
    logic              word_full, start_ok;
    logic              len_bad, pk_en, last;

    assign start_ok = start &&
        (state == IDLE || state == DONE || state == ERR);
    assign len_bad  = (byte_data == 8'd0) ||
        (32'(byte_data) > MEM_WORDS);
    assign pk_en    = byte_valid && (state == DATA);
    assign cnt_inc  = cnt + CNT_W'(1);
    assign last     = (cnt_inc == n_len);

    word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .byte_en   (pk_en),
        .byte_data (byte_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) nxt = LEN;
            LEN:   if (byte_valid) nxt = len_bad ? ERR : DATA;
            DATA:  if (word_full) nxt = WRITE;
            WRITE: nxt = last ? DONE : DATA;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            n_len <= '0;
        end else begin
            if (start_ok)
                cnt <= '0;
            else if (state == WRITE)
                cnt <= cnt_inc;
            if (state == LEN && byte_valid && !len_bad)
                n_len <= CNT_W'(byte_data);
        end
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        unique case (1'b1)
            (state == LEN),
            (state == DATA): byte_ready = 1'b1;
            (state == WRITE): begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'({cnt, 2'b00});
                mem_wdata = word;
            end
            (state == DONE): begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            (state == ERR): err = 1'b1;
            default: ;
        endcase
    end

    assign words_loaded = cnt;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [5:0]  words_loaded;

    int n_cmp = 0;
    int n_bad = 0;
    int nw = 0;
    int lowcnt = 0;
    bit trk = 1'b0;
    logic [31:0] wa [8];
    logic [31:0] wd [8];

    always #5 clk = ~clk;

    inst_loader #(.MEM_WORDS(32), .ADDR_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always @(posedge clk) begin
        if (mem_we && nw < 8) begin
            wa[nw] = 32'(mem_addr);
            wd[nw] = mem_wdata;
        end
        if (mem_we) nw = nw + 1;
        if (trk && !byte_ready) lowcnt = lowcnt + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        while (!byte_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!byte_ready) chk("send_timeout", 32'(byte_ready), 1);
        tick();
    endtask

    task automatic gap(input int c);
        byte_valid = 1'b0;
        repeat (c) tick();
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(done), 1);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_ready"}, 32'(byte_ready), 0);
        chk({p, "_we"},    32'(mem_we), 0);
        chk({p, "_addr"},  32'(mem_addr), 0);
        chk({p, "_wdata"}, mem_wdata, 0);
        chk({p, "_hold"},  32'(cpu_hold), 1);
        chk({p, "_done"},  32'(done), 0);
        chk({p, "_err"},   32'(err), 0);
        chk({p, "_words"}, 32'(words_loaded), 0);
    endtask

    logic [7:0] t2 [12] = '{8'h01, 8'h02, 8'h03, 8'h04,
                            8'h05, 8'h06, 8'h07, 8'h08,
                            8'h09, 8'h0A, 8'h0B, 8'h0C};
    logic [7:0] t4 [8]  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE,
                            8'h78, 8'h56, 8'h34, 8'h12};

    initial begin
        repeat (2) tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();

        // single-word load
        pulse_start();
        chk("len_ready", 32'(byte_ready), 1);
        send(8'd1);
        send(8'hB3); send(8'h80); send(8'h11); send(8'h40);
        byte_valid = 1'b0;
        chk("w1_we", 32'(mem_we), 1);
        chk("w1_addr", 32'(mem_addr), 32'h0);
        chk("w1_data", mem_wdata, 32'h401180B3);
        chk("w1_ready", 32'(byte_ready), 0);
        chk("w1_hold", 32'(cpu_hold), 1);
        tick();
        chk("w1_done", 32'(done), 1);
        chk("w1_hold2", 32'(cpu_hold), 0);
        chk("w1_words", 32'(words_loaded), 1);
        chk("w1_we_off", 32'(mem_we), 0);
        byte_valid = 1'b1;
        byte_data = 8'h55;
        repeat (3) tick();
        byte_valid = 1'b0;
        chk("w1_nw", 32'(nw), 1);

        // three words gap-free, restart from DONE
        nw = 0;
        pulse_start();
        chk("r2_done_clr", 32'(done), 0);
        chk("r2_hold", 32'(cpu_hold), 1);
        chk("r2_words", 32'(words_loaded), 0);
        lowcnt = 0;
        trk = 1'b1;
        send(8'd3);
        for (int i = 0; i < 12; i++) send(t2[i]);
        byte_valid = 1'b0;
        wait_done("r2_wait");
        trk = 1'b0;
        chk("r2_low", 32'(lowcnt), 3);
        chk("r2_nw", 32'(nw), 3);
        chk("r2_a0", wa[0], 32'h0);
        chk("r2_a1", wa[1], 32'h4);
        chk("r2_a2", wa[2], 32'h8);
        chk("r2_d0", wd[0], 32'h04030201);
        chk("r2_d1", wd[1], 32'h08070605);
        chk("r2_d2", wd[2], 32'h0C0B0A09);
        chk("r2_cnt", 32'(words_loaded), 3);

        // illegal lengths
        nw = 0;
        pulse_start();
        send(8'h00);
        byte_valid = 1'b0;
        chk("e0_err", 32'(err), 1);
        chk("e0_hold", 32'(cpu_hold), 1);
        chk("e0_ready", 32'(byte_ready), 0);
        pulse_start();
        chk("e0_clr", 32'(err), 0);
        chk("e0_len", 32'(byte_ready), 1);
        send(8'h21);
        byte_valid = 1'b0;
        chk("e21_err", 32'(err), 1);
        chk("e21_hold", 32'(cpu_hold), 1);
        repeat (2) tick();
        chk("e_nw", 32'(nw), 0);
        pulse_start();
        chk("e21_clr", 32'(err), 0);

        // two words with random valid gaps (already in LEN)
        send(8'd2);
        for (int i = 0; i < 8; i++) begin
            gap($urandom_range(0, 3));
            send(t4[i]);
        end
        byte_valid = 1'b0;
        wait_done("g_wait");
        chk("g_nw", 32'(nw), 2);
        chk("g_d0", wd[0], 32'hDEADBEEF);
        chk("g_d1", wd[1], 32'h12345678);
        chk("g_a1", wa[1], 32'h4);

        // reset mid-load after six data bytes
        nw = 0;
        pulse_start();
        send(8'd2);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66);
        byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk_reset("mid");
        rst = 1'b0;
        repeat (5) tick();
        chk("mid_nw", 32'(nw), 1);
        chk("mid_d0", wd[0], 32'h44332211);

        // start during DATA ignored
        nw = 0;
        pulse_start();
        send(8'd1);
        send(8'h93); send(8'h00);
        byte_valid = 1'b0;
        pulse_start();
        chk("sd_ready", 32'(byte_ready), 1);
        send(8'h10); send(8'h00);
        byte_valid = 1'b0;
        wait_done("sd_wait");
        chk("sd_nw", 32'(nw), 1);
        chk("sd_d0", wd[0], 32'h00100093);

        // start in DONE begins a fresh load
        nw = 0;
        pulse_start();
        chk("sdn_done", 32'(done), 0);
        chk("sdn_hold", 32'(cpu_hold), 1);
        send(8'd1);
        send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
        byte_valid = 1'b0;
        wait_done("sdn_wait");
        chk("sdn_d0", wd[0], 32'h0000006F);
        chk("sdn_a0", wa[0], 32'h0);
        chk("sdn_words", 32'(words_loaded), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that fills the instruction memory through its write port from a byte stream (UART receiver or testbench), holding the CPU until the image is complete. It accepts a length byte and little-endian instruction bytes, packs them into 32-bit words and issues one word write per instruction at word-aligned byte addresses. It sits between the serial front end and the instruction memory; the fetch path reads the memory only after `done`.

## Interface
Parameters:
- `MEM_WORDS`, 32: instruction memory depth in words; also the legal maximum program length.
- `ADDR_W`, 10: byte-address width of the instruction memory port.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `byte_valid` input 1: `byte_data` is valid this cycle.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader accepts a byte this cycle; transfer when `byte_valid && byte_ready`.
- `mem_we` output 1: one-cycle word write strobe to the instruction memory.
- `mem_addr` output ADDR_W: byte address, always a multiple of 4.
- `mem_wdata` output 32: assembled instruction word.
- `cpu_hold` output 1: keeps the CPU stalled or in reset while high.
- `done` output 1: complete image loaded.
- `err` output 1: illegal length byte received.
- `words_loaded` output clog2(MEM_WORDS+1): count of words written so far.

## Operation
- States: IDLE, LEN, DATA, WRITE, DONE, ERR.
- IDLE: `byte_ready`=0. `start` moves to LEN and clears `done`, `err`, `words_loaded` and the byte lane counter.
- LEN: `byte_ready`=1. The accepted byte is N.
  - N = 0 or N > MEM_WORDS: go to ERR.
  - Otherwise latch N and go to DATA.
- DATA: `byte_ready`=1. Each accepted byte fills lane `lane` of the word: lane 0 is bits[7:0], lane 3 is bits[31:24]. `lane` is a 2-bit counter. Accepting lane 3 moves to WRITE.
- WRITE: one cycle. `mem_we`=1, `mem_addr`=4*`words_loaded`, `mem_wdata`=the packed word, `byte_ready`=0. At the end of the cycle `words_loaded` increments. If the new count equals N, go to DONE; else return to DATA.
- DONE: `done`=1, `cpu_hold`=0, `byte_ready`=0. Extra stream bytes are not accepted.
- ERR: `err`=1, `cpu_hold`=1, `byte_ready`=0. Any prior writes are left in memory.
- `cpu_hold` is 1 in every state except DONE.
- `mem_addr` arithmetic: `words_loaded` zero-extended to ADDR_W, then shifted left by 2. N ≤ MEM_WORDS guarantees no wrap.
- `start` in LEN, DATA or WRITE is ignored; a load cannot be restarted mid-stream except by `rst`.
- `byte_valid` while `byte_ready`=0: the byte is not consumed, and the source must hold it.

## Timing
- Reset values: state IDLE, `byte_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 1, `done` 0, `err` 0, `words_loaded` 0, `lane` 0.
- `rst` mid-load aborts on the next edge: no further `mem_we`, and the partial word is discarded.
- Outputs are registered from state; `byte_ready` is a function of state only, with no combinational path from `byte_valid`.
- Latency: lane-3 byte accepted at edge k gives `mem_we` high during cycle k+1. The next byte can be accepted at edge k+2. Sustained throughput is 1 word per 5 cycles.
- The DONE transition coincides with the final WRITE's end. `done` rises and `cpu_hold` falls in the cycle after the last `mem_we`.
- `start` and `rst` in the same cycle: `rst` wins.

## Structure
- Shared package `loader_pkg`:
  - state enum `ld_state_t`
  - `MEM_WORDS` default
  - `LANE_W`=2
  - `WORD_BYTES`=4
- Sub-module `word_packer`: lane counter plus 32-bit shift/insert register, with inputs `clk`, `rst`, `clr`, `byte_en`, `byte_data` and outputs `word`, `word_full`. The top-level FSM owns addressing, counting and handshake.

## Test plan
- Length 1, bytes 0xB3,0x80,0x11,0x40 → exactly one `mem_we` with addr 0x000 and data 0x401180B3; `done`=1 and `cpu_hold`=0 one cycle later; `words_loaded`=1.
- Length 3, gap-free valid stream → writes at addr 0x000, 0x004, 0x008; `byte_ready` low exactly in each WRITE cycle; `done` after the third write.
- Length byte 0x00, and separately 0x21 with MEM_WORDS=32 → `err`=1, no `mem_we`, `cpu_hold` stays 1; a subsequent `start` clears `err` and re-enters LEN.
- Random `byte_valid` gaps during a 2-word load → word contents unchanged versus gap-free; no byte lost or duplicated.
- `rst` asserted after 6 data bytes of a 2-word load → first word was written, no second `mem_we`; all outputs at reset values on the next cycle.
- `start` pulsed during DATA → ignored, load completes normally; `start` in DONE → `done` clears, `cpu_hold` reasserts, new load proceeds.
